// File: rtl/qspi_txn_sched.sv
// Round-robin read/write scheduler in front of the QSPI controller, with a
// post-program status poll loop. Define SCHED_TIMEOUT_EN to bound the poll loop at MAX_POLLS.
module qspi_txn_sched #(
  parameter int unsigned POLL_GAP_CYCLES = 16,
  parameter int unsigned MAX_POLLS       = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd_req,
  input  logic [23:0] i_rd_addr,
  input  logic [7:0]  i_rd_len,
  output logic        o_rd_ack,
  output logic        o_rd_done,
  input  logic        i_wr_req,
  input  logic [23:0] i_wr_addr,
  input  logic [7:0]  i_wr_len,
  output logic        o_wr_ack,
  output logic        o_wr_done,
  output logic        o_wr_err,
  output logic        o_read,
  output logic        o_write,
  output logic [23:0] o_addr,
  output logic [7:0]  o_byte_count,
  input  logic        i_complete,
  output logic        o_poll,
  input  logic        i_poll_done,
  input  logic [7:0]  i_status,
  output logic        o_busy
);

  localparam int unsigned PCW      = $clog2(MAX_POLLS + 1);
  localparam logic [7:0]  GAP_LOAD = 8'(POLL_GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_RUN   = 3'd1,
    S_WR_RUN   = 3'd2,
    S_POLL_GAP = 3'd3,
    S_POLL_RUN = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_wr_q, ptr_wr_d;    // 1: write wins the next tie
  logic [7:0]       gap_q, gap_d;
  logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [PCW-1:0]   poll_cnt_inc_s;
  logic             rd_ack_q, rd_ack_d;
  logic             rd_done_q, rd_done_d;
  logic             wr_ack_q, wr_ack_d;
  logic             wr_done_q, wr_done_d;
  logic             wr_err_q, wr_err_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             poll_q, poll_d;
  logic             busy_q, busy_d;
  logic [23:0]      addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic             unused_status_s;

  // Only the write-in-progress bit of the status byte matters here.
  assign unused_status_s = ^i_status[7:1];

  // Saturating poll count increment.
  always_comb begin
    if (poll_cnt_q == {PCW{1'b1}}) begin
      poll_cnt_inc_s = poll_cnt_q;
    end else begin
      poll_cnt_inc_s = poll_cnt_q + PCW'(1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_wr_d   = ptr_wr_q;
    gap_d      = gap_q;
    poll_cnt_d = poll_cnt_q;
    rd_ack_d   = 1'b0;
    rd_done_d  = 1'b0;
    wr_ack_d   = 1'b0;
    wr_done_d  = 1'b0;
    wr_err_d   = 1'b0;
    read_d     = 1'b0;
    write_d    = 1'b0;
    poll_d     = 1'b0;
    addr_d     = addr_q;
    len_d      = len_q;

    case (state_q)
      S_IDLE: begin
        if (i_rd_req && (!i_wr_req || !ptr_wr_q)) begin
          state_d  = S_RD_RUN;
          rd_ack_d = 1'b1;
          read_d   = 1'b1;
          addr_d   = i_rd_addr;
          len_d    = i_rd_len;
          ptr_wr_d = 1'b1;
        end else if (i_wr_req) begin
          state_d    = S_WR_RUN;
          wr_ack_d   = 1'b1;
          write_d    = 1'b1;
          addr_d     = i_wr_addr;
          len_d      = i_wr_len;
          ptr_wr_d   = 1'b0;
          poll_cnt_d = {PCW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD_RUN: begin
        if (i_complete) begin
          state_d   = S_IDLE;
          rd_done_d = 1'b1;
        end else begin
          read_d = 1'b1;
        end
      end

      S_WR_RUN: begin
        if (i_complete) begin
          state_d = S_POLL_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          write_d = 1'b1;
        end
      end

      // gap_q counts down the quiet cycles before each status read
      S_POLL_GAP: begin
        if (gap_q <= 8'd1) begin
          state_d = S_POLL_RUN;
          gap_d   = 8'd0;
          poll_d  = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      S_POLL_RUN: begin
        if (i_poll_done) begin
          poll_cnt_d = poll_cnt_inc_s;
          if (i_status[0]) begin
`ifdef SCHED_TIMEOUT_EN
            if (poll_cnt_q >= PCW'(MAX_POLLS - 1)) begin
              state_d   = S_IDLE;
              wr_done_d = 1'b1;
              wr_err_d  = 1'b1;
            end else begin
              state_d = S_POLL_GAP;
              gap_d   = GAP_LOAD;
            end
`else
            state_d = S_POLL_GAP;
            gap_d   = GAP_LOAD;
`endif
          end else begin
            state_d   = S_IDLE;
            wr_done_d = 1'b1;
          end
        end else begin
          poll_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_wr_q   <= 1'b0;
      gap_q      <= 8'd0;
      poll_cnt_q <= {PCW{1'b0}};
      rd_ack_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      poll_q     <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= 24'd0;
      len_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_wr_q   <= ptr_wr_d;
      gap_q      <= gap_d;
      poll_cnt_q <= poll_cnt_d;
      rd_ack_q   <= rd_ack_d;
      rd_done_q  <= rd_done_d;
      wr_ack_q   <= wr_ack_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
      read_q     <= read_d;
      write_q    <= write_d;
      poll_q     <= poll_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

  assign o_rd_ack     = rd_ack_q;
  assign o_rd_done    = rd_done_q;
  assign o_wr_ack     = wr_ack_q;
  assign o_wr_done    = wr_done_q;
  assign o_wr_err     = wr_err_q;
  assign o_read       = read_q;
  assign o_write      = write_q;
  assign o_poll       = poll_q;
  assign o_busy       = busy_q;
  assign o_addr       = addr_q;
  assign o_byte_count = len_q;

endmodule

// File: tb/tb_qspi_txn_sched.sv
// Directed bench for qspi_txn_sched: stimulus pushes cycle-stamped output
// snapshots into a scoreboard; a negedge monitor pops and compares them.
module tb_qspi_txn_sched;

  localparam int G    = 4;
  localparam int MAXP = 3;
`ifdef SCHED_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  // flag order: rd_ack rd_done wr_ack wr_done wr_err read write poll busy
  localparam logic [8:0] F_RDACK  = 9'b100000000;
  localparam logic [8:0] F_RDDONE = 9'b010000000;
  localparam logic [8:0] F_WRACK  = 9'b001000000;
  localparam logic [8:0] F_WRDONE = 9'b000100000;
  localparam logic [8:0] F_WRERR  = 9'b000010000;
  localparam logic [8:0] F_RD     = 9'b000001000;
  localparam logic [8:0] F_WR     = 9'b000000100;
  localparam logic [8:0] F_POLL   = 9'b000000010;
  localparam logic [8:0] F_BUSY   = 9'b000000001;
  localparam logic [8:0] F_NONE   = 9'b000000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rd_req, i_wr_req, i_complete, i_poll_done;
  logic [23:0] i_rd_addr, i_wr_addr;
  logic [7:0]  i_rd_len, i_wr_len, i_status;
  logic        o_rd_ack, o_rd_done, o_wr_ack, o_wr_done, o_wr_err;
  logic        o_read, o_write, o_poll, o_busy;
  logic [23:0] o_addr;
  logic [7:0]  o_byte_count;

  qspi_txn_sched #(.POLL_GAP_CYCLES(G), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len),
    .o_rd_ack(o_rd_ack), .o_rd_done(o_rd_done),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_len(i_wr_len),
    .o_wr_ack(o_wr_ack), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
    .o_read(o_read), .o_write(o_write), .o_addr(o_addr), .o_byte_count(o_byte_count),
    .i_complete(i_complete), .o_poll(o_poll), .i_poll_done(i_poll_done),
    .i_status(i_status), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [40:0] vec;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  status_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] last_addr = 24'h0;
  logic [7:0]  last_len = 8'h0;
  logic        prev_poll = 1'b0;

  function automatic logic [40:0] mk(input logic [8:0] f);
    return {f, last_addr, last_len};
  endfunction

  task automatic push(input int c, input string n, input logic [40:0] v);
    exp_t e;
    int   i;
    e.cyc = c; e.name = n; e.vec = v;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > c) i--;
    sbq.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare scheduled snapshots, flag any output event nobody expected.
  always @(negedge clk) begin
    logic [40:0] obs;
    logic        ev;
    exp_t        e;
    obs = {o_rd_ack, o_rd_done, o_wr_ack, o_wr_done, o_wr_err,
           o_read, o_write, o_poll, o_busy, o_addr, o_byte_count};
    ev = ((o_rd_ack | o_rd_done | o_wr_ack | o_wr_done | o_wr_err) === 1'b1) ||
         (o_poll === 1'b1 && prev_poll == 1'b0);
    prev_poll = (o_poll === 1'b1);
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      vectors++; miscompares++;
      $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL %s @cyc %0d: got %h required %h", e.name, cyc, obs, e.vec);
      end
    end else if (ev) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_event @cyc %0d: got %h", cyc, obs);
    end
  end

  task automatic do_read(input logic [23:0] a, input logic [7:0] l, input int run);
    int c;
    c = cyc;
    i_rd_req = 1'b1; i_rd_addr = a; i_rd_len = l;
    last_addr = a; last_len = l;
    push(c + 1, "rd_ack", mk(F_RDACK | F_RD | F_BUSY));
    for (int i = 2; i <= run + 1; i++) push(c + i, "rd_run", mk(F_RD | F_BUSY));
    step(1);
    i_rd_req = 1'b0; i_rd_addr = 24'h0; i_rd_len = 8'h0;
    step(run);
    i_complete = 1'b1;
    push(cyc + 1, "rd_done", mk(F_RDDONE));
    step(1);
    i_complete = 1'b0;
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] l, input int run,
                          input bit rd_during, input bit rst_in_poll);
    int         c, np;
    bit         fin;
    logic [7:0] s;
    c = cyc;
    i_wr_req = 1'b1; i_wr_addr = a; i_wr_len = l;
    last_addr = a; last_len = l;
    push(c + 1, "wr_ack", mk(F_WRACK | F_WR | F_BUSY));
    for (int i = 2; i <= run + 1; i++) push(c + i, "wr_run", mk(F_WR | F_BUSY));
    step(1);
    i_wr_req = 1'b0; i_wr_addr = 24'h0; i_wr_len = 8'h0;
    if (rd_during) i_rd_req = 1'b1;
    step(run);
    i_complete = 1'b1;
    push(cyc + 1, "wr_to_gap", mk(F_BUSY));
    push(cyc + 1 + G, "poll_rise", mk(F_POLL | F_BUSY));
    step(1);
    i_complete = 1'b0;
    step(G);
    np = 0; fin = 1'b0;
    while (!fin) begin
      if (rst_in_poll) begin
        rst_n = 1'b0;
        last_addr = 24'h0; last_len = 8'h0;
        push(cyc + 1, "rst_in_poll", mk(F_NONE));
        push(cyc + 2, "after_rst", mk(F_NONE));
        step(1);
        rst_n = 1'b1;
        step(1);
        fin = 1'b1;
      end else begin
        push(cyc + 1, "poll_hold", mk(F_POLL | F_BUSY));
        step(1);
        s = status_q.pop_front();
        i_poll_done = 1'b1; i_status = s;
        np++;
        fin = !s[0] || (TIMEOUT && np == MAXP);
        if (!s[0]) push(cyc + 1, "wr_done", mk(F_WRDONE));
        else if (fin) push(cyc + 1, "wr_timeout", mk(F_WRDONE | F_WRERR));
        else begin
          push(cyc + 1, "poll_to_gap", mk(F_BUSY));
          push(cyc + 1 + G, "poll_rise", mk(F_POLL | F_BUSY));
        end
        step(1);
        i_poll_done = 1'b0; i_status = 8'h00;
        if (!fin) step(G);
      end
    end
    status_q.delete();
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    i_rd_req = 1'b0; i_wr_req = 1'b0; i_complete = 1'b0; i_poll_done = 1'b0;
    i_rd_addr = 24'h0; i_wr_addr = 24'h0; i_rd_len = 8'h0; i_wr_len = 8'h0;
    i_status = 8'h00;
    push(1, "reset", mk(F_NONE));
    push(2, "reset_hold", mk(F_NONE));
    step(2);
    rst_n = 1'b1;
    step(1);

    // Tie after reset: read first, pending write acked after rd_done.
    i_wr_req = 1'b1; i_wr_addr = 24'hABCDEF; i_wr_len = 8'h20;
    do_read(24'h000100, 8'h08, 2);
    status_q = '{8'h00};
    do_write(24'hABCDEF, 8'h20, 1, 1'b0, 1'b0);

    // Second tie: last grant was write, so read wins again.
    i_wr_req = 1'b1; i_wr_addr = 24'h00F000; i_wr_len = 8'h04;
    do_read(24'h000200, 8'h01, 1);
    status_q = '{8'h00};
    do_write(24'h00F000, 8'h04, 2, 1'b0, 1'b0);

    do_read(24'h001234, 8'd16, 3);

    // Spurious completion pulses while idle.
    c = cyc;
    for (int i = 1; i <= 5; i++) push(c + i, "idle_spurious", mk(F_NONE));
    i_complete = 1'b1; step(1);
    i_complete = 1'b0; i_poll_done = 1'b1; i_status = 8'h01; step(1);
    i_complete = 1'b1; i_status = 8'h00; step(1);
    i_complete = 1'b0; i_poll_done = 1'b0; step(2);

    // Write with busy status twice; read raised during WR_RUN waits for wr_done.
    status_q = '{8'h01, 8'h01, 8'h00};
    do_write(24'h040000, 8'hFF, 2, 1'b1, 1'b0);
    do_read(24'h000777, 8'h02, 1);

    // Stuck busy status: times out at MAXP polls when enabled, else continues.
    status_q = '{8'h01, 8'h01, 8'h01, 8'h81, 8'h00};
    do_write(24'h100000, 8'h80, 1, 1'b0, 1'b0);

    do_write(24'h200000, 8'h10, 1, 1'b0, 1'b1);
    status_q = '{8'h00};
    do_write(24'h300000, 8'h40, 1, 1'b0, 1'b0);

    step(4);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++; miscompares++;
      $display("FAIL %s never checked: due cyc %0d", e.name, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
